// File: rtl/pmod_result_sender.sv
// Serial PMOD transmitter: latches {mode,result}, requests the link with t_sync,
// and once the remote acknowledges shifts the 129-bit frame out MSB first on TxD.
module pmod_result_sender #(
   parameter int BIT_CYCLES  = 1,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         reset_b,
   input  logic         enable,
   input  logic         start,
   input  logic [127:0] result,
   input  logic         mode,
   input  logic         r_acknowledge,
   output logic         TxD,
   output logic         t_sync,
   output logic         busy,
   output logic         done,
   output logic         error
);

   localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, SEND, FIN} state_t;

   state_t         state;
   logic [128:0]   shreg;
   logic [7:0]     bit_cntr;
   logic [HW-1:0]  hold_cntr;
   logic [TW-1:0]  tout_cntr;

   // Every output is a flop updated alongside the state, so nothing reaches the
   // pins combinationally from an input.
   always_ff @(posedge clk) begin
      if (reset_b) begin
         state     <= IDLE;
         // NOTE: the shift register is reset too, although its contents are
         // only read after a load, so the reset state is fully defined.
         shreg     <= '0;
         bit_cntr  <= '0;
         hold_cntr <= '0;
         tout_cntr <= '0;
         TxD       <= 1'b0;
         t_sync    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments everywhere here; every branch below
         // reads the pre-edge value of shreg and the counters.
         done  <= 1'b0;
         error <= 1'b0;
         if (enable) begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     shreg     <= {mode, result};
                     tout_cntr <= '0;
                     TxD       <= 1'b0;
                     t_sync    <= 1'b1;
                     busy      <= 1'b1;
                     state     <= REQ;
                  end
               end
               REQ: begin
                  if (r_acknowledge) begin
                     bit_cntr  <= '0;
                     hold_cntr <= '0;
                     TxD       <= shreg[128];
                     state     <= SEND;
                  end else if (tout_cntr == TOUT_LAST) begin
                     error  <= 1'b1;
                     t_sync <= 1'b0;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     tout_cntr <= tout_cntr + 1'b1;
                  end
               end
               SEND: begin
                  if (!r_acknowledge) begin
                     // Ack lost mid-frame: the partial frame is abandoned.
                     error  <= 1'b1;
                     t_sync <= 1'b0;
                     TxD    <= 1'b0;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end else if (hold_cntr == HOLD_LAST) begin
                     hold_cntr <= '0;
                     if (bit_cntr == 8'd128) begin
                        done   <= 1'b1;
                        t_sync <= 1'b0;
                        TxD    <= 1'b0;
                        state  <= FIN;
                     end else begin
                        shreg    <= {shreg[127:0], 1'b0};
                        TxD      <= shreg[127];
                        bit_cntr <= bit_cntr + 1'b1;
                     end
                  end else begin
                     hold_cntr <= hold_cntr + 1'b1;
                  end
               end
               FIN: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pmod_result_sender.sv
// Self-checking bench for pmod_result_sender: two instances (1 and 4 cycles per bit)
// are compared every cycle against a frame/time model, plus hand-computed pins.
module tb_pmod_result_sender;

   localparam int TIMEOUT = 16;
   localparam logic [127:0] R1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] R2 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

   logic         clk = 1'b0;
   logic         reset_b, enable, start, mode, ack;
   logic [127:0] result;
   logic [1:0]   txd, tsync, busy_o, done_o, err_o;

   pmod_result_sender #(.BIT_CYCLES(1), .ACK_TIMEOUT(TIMEOUT)) dut_b1 (
      .clk(clk), .reset_b(reset_b), .enable(enable), .start(start), .result(result),
      .mode(mode), .r_acknowledge(ack), .TxD(txd[0]), .t_sync(tsync[0]),
      .busy(busy_o[0]), .done(done_o[0]), .error(err_o[0]));

   pmod_result_sender #(.BIT_CYCLES(4), .ACK_TIMEOUT(TIMEOUT)) dut_b4 (
      .clk(clk), .reset_b(reset_b), .enable(enable), .start(start), .result(result),
      .mode(mode), .r_acknowledge(ack), .TxD(txd[1]), .t_sync(tsync[1]),
      .busy(busy_o[1]), .done(done_o[1]), .error(err_o[1]));

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   int s_edge;
   bit chk_on   = 1'b0;

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Model: a link is idle, waiting for ack, transferring (t enabled edges since
   // ack) or finishing; the bit on the wire is frame[128 - t/bit_cycles].
   typedef enum {P_IDLE, P_WAIT, P_XFER, P_FIN} phase_t;
   phase_t       phase[2];
   int           wait_cnt[2], t[2];
   logic [128:0] frame[2];
   logic         m_done[2], m_err[2];

   function automatic int bc(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         phase[i] = P_IDLE; wait_cnt[i] = 0; t[i] = 0; frame[i] = '0;
         m_done[i] = 1'b0; m_err[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      edge_n++;
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         m_err[i]  = 1'b0;
         if (reset_b) begin
            phase[i] = P_IDLE;
         end else if (enable) begin
            case (phase[i])
               P_IDLE: if (start) begin
                  frame[i] = {mode, result}; wait_cnt[i] = 0; phase[i] = P_WAIT;
               end
               P_WAIT: if (ack) begin
                  phase[i] = P_XFER; t[i] = 0;
               end else begin
                  wait_cnt[i]++;
                  if (wait_cnt[i] == TIMEOUT) begin m_err[i] = 1'b1; phase[i] = P_IDLE; end
               end
               P_XFER: if (!ack) begin
                  m_err[i] = 1'b1; phase[i] = P_IDLE;
               end else begin
                  t[i]++;
                  if (t[i] == 129 * bc(i)) begin m_done[i] = 1'b1; phase[i] = P_FIN; end
               end
               P_FIN: phase[i] = P_IDLE;
               default: phase[i] = P_IDLE;
            endcase
         end
      end
   end

   function automatic logic exp_txd(input int i);
      if (phase[i] == P_XFER) return frame[i][128 - t[i] / bc(i)];
      return 1'b0;
   endfunction

   int done_cnt[2]  = '{0, 0};
   int err_cnt[2]   = '{0, 0};
   int done_edge[2] = '{0, 0};
   int err_edge[2]  = '{0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (chk_on) begin
            check($sformatf("dut%0d.TxD", i),    129'(txd[i]),    129'(exp_txd(i)));
            check($sformatf("dut%0d.t_sync", i), 129'(tsync[i]),
                  129'(phase[i] == P_WAIT || phase[i] == P_XFER));
            check($sformatf("dut%0d.busy", i),   129'(busy_o[i]), 129'(phase[i] != P_IDLE));
            check($sformatf("dut%0d.done", i),   129'(done_o[i]), 129'(m_done[i]));
            check($sformatf("dut%0d.error", i),  129'(err_o[i]),  129'(m_err[i]));
         end
         if (done_o[i] === 1'b1) begin done_cnt[i]++; done_edge[i] = edge_n; end
         if (err_o[i] === 1'b1)  begin err_cnt[i]++;  err_edge[i]  = edge_n; end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_start(input logic m, input logic [127:0] r);
      mode = m; result = r; start = 1'b1;
      s_edge = edge_n + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic capture0(output logic [128:0] bits);
      for (int j = 128; j >= 0; j--) begin
         @(negedge clk);
         bits[j] = txd[0];
      end
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while (busy_o !== 2'b00 && k < limit) begin
         @(negedge clk);
         k++;
      end
      check("wait_idle_bound", 129'(busy_o), 129'(0));
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".TxD"},    129'(txd),    129'(0));
      check({tag, ".t_sync"}, 129'(tsync),  129'(0));
      check({tag, ".busy"},   129'(busy_o), 129'(0));
      check({tag, ".done"},   129'(done_o), 129'(0));
      check({tag, ".error"},  129'(err_o),  129'(0));
   endtask

   initial begin
      logic [128:0] bits;
      int k, hi;
      reset_b = 1'b1; enable = 1'b1; start = 1'b0; mode = 1'b0; ack = 1'b0; result = '0;
      cyc(3);
      check_quiet("reset");
      reset_b = 1'b0;
      chk_on  = 1'b1;
      cyc(1);

      // Basic frame, ack raised two cycles after t_sync.
      send_start(1'b1, R1);
      cyc(1);
      ack = 1'b1; k = edge_n + 1;
      capture0(bits);
      check("basic.frame", bits, {1'b1, R1});
      cyc(2);
      check("basic.done_cnt_b1", 129'(done_cnt[0]), 129'(1));
      check("basic.done_lat_b1", 129'(done_edge[0] - k), 129'(129));
      wait_idle(700);
      check("basic.done_lat_b4", 129'(done_edge[1] - k), 129'(516));
      ack = 1'b0;

      // Ack already high on entry to REQ; 4-cycle bits of 0,1,0...0,1.
      cyc(2);
      ack = 1'b1;
      send_start(1'b0, R2);
      k = s_edge + 1; hi = 0;
      for (int j = 0; j < 700; j++) begin
         if (txd[1] === 1'b1) hi++;
         if (busy_o[1] === 1'b0) break;
         @(negedge clk);
      end
      check("b4.high_cycles", 129'(hi), 129'(8));
      check("b4.done_lat", 129'(done_edge[1] - k), 129'(516));
      check("b4.done_lat_b1", 129'(done_edge[0] - k), 129'(129));
      check("b4.done_cnt", 129'(done_cnt[1]), 129'(2));
      ack = 1'b0;

      // No acknowledge at all: timeout.
      cyc(2);
      send_start(1'b1, R1);
      cyc(25);
      check("tout.err_cnt", 129'(err_cnt[0] + err_cnt[1]), 129'(2));
      check("tout.err_lat_b1", 129'(err_edge[0] - s_edge), 129'(TIMEOUT));
      check("tout.err_lat_b4", 129'(err_edge[1] - s_edge), 129'(TIMEOUT));
      check("tout.done_cnt", 129'(done_cnt[0]), 129'(2));
      check_quiet("tout.after");

      // Ack dropped right after bit 40, then a clean frame.
      ack = 1'b1;
      send_start(1'b0, R1);
      cyc(41);
      ack = 1'b0;
      cyc(3);
      check("drop.err_cnt", 129'(err_cnt[0] + err_cnt[1]), 129'(4));
      check_quiet("drop.after");
      ack = 1'b1;
      send_start(1'b1, R2);
      capture0(bits);
      check("drop.refrm", bits, {1'b1, R2});
      wait_idle(700);
      check("drop.done_cnt", 129'(done_cnt[0] + done_cnt[1]), 129'(6));
      ack = 1'b0;

      // Ignored start mid-frame, then a 10-cycle enable freeze.
      cyc(2);
      ack = 1'b1;
      send_start(1'b1, R1);
      k = s_edge + 1;
      cyc(19);
      send_start(1'b0, R2);
      cyc(10);
      enable = 1'b0;
      cyc(10);
      enable = 1'b1;
      wait_idle(700);
      check("frz.done_lat_b1", 129'(done_edge[0] - k), 129'(139));
      check("frz.done_lat_b4", 129'(done_edge[1] - k), 129'(526));
      cyc(3);
      check("frz.no_restart", 129'(busy_o), 129'(0));
      ack = 1'b0;

      // Reset at bit 60, then reset coincident with start.
      cyc(2);
      ack = 1'b1;
      send_start(1'b0, R2);
      cyc(61);
      reset_b = 1'b1;
      cyc(1);
      check_quiet("rst60");
      reset_b = 1'b0;
      ack = 1'b0;
      cyc(2);
      reset_b = 1'b1; start = 1'b1; mode = 1'b1; result = R1;
      cyc(1);
      start = 1'b0; reset_b = 1'b0;
      check_quiet("rst_start");
      cyc(4);
      check("rst_start.busy", 129'(busy_o), 129'(0));
      check("rst_start.done_cnt", 129'(done_cnt[0] + done_cnt[1]), 129'(8));

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got edge %0d, expected completion", edge_n);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pmod_result_sender.md
# pmod_result_sender

Serial PMOD transmitter that returns the Anubis cipher result from the Basys3 to the remote device. It sits downstream of the cipher core. It latches the 128-bit result and the mode bit, then requests the link with `t_sync` and waits for the remote `r_acknowledge`. Once acknowledged, it shifts a 129-bit frame out on `TxD`. The frame order is the one the PMOD receiver expects: mode bit first, then result MSB to LSB.

## Interface
Parameters:
- BIT_CYCLES, 1 — clock cycles each bit is held on TxD; legal range ≥1.
- ACK_TIMEOUT, 1024 — cycles spent waiting in REQ for r_acknowledge before aborting; legal range ≥1.

Ports:
- clk  in  1  onboard 100 MHz clock; the only clock.
- reset_b  in  1  reset, synchronous, active-high (named as in the codebase).
- enable  in  1  module enable; low freezes all state.
- start  in  1  one-cycle pulse from the cipher core: result is valid.
- result  in  128  cipher output; sampled only on an accepted start.
- mode  in  1  encrypt (1) or decrypt (0) mode of the result; sampled with result.
- r_acknowledge  in  1  remote device accepts the Basys3 transfer request.
- TxD  out  1  serial data.
- t_sync  out  1  Basys3 request to sync; remote samples while t_sync && r_acknowledge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: frame fully sent.
- error  out  1  one-cycle pulse: ack timeout or ack lost mid-frame.

## Operation
- Frame is 129 bits: frame[128] = mode, frame[127:0] = result. The shift register sends its MSB first.
- States are IDLE, REQ, SEND and FIN.
- IDLE: TxD=0, t_sync=0. If start && enable, load the shift register with {mode,result}, clear the timeout counter, and go to REQ.
  - start while busy is ignored; no queueing.
- REQ: t_sync=1 and TxD=0. The timeout counter increments each enabled cycle.
  - If r_acknowledge=1, clear bit_cntr (8 bits) and the hold counter, then go to SEND.
  - Else, if the timeout counter reaches ACK_TIMEOUT-1, pulse error, drop t_sync and go to IDLE.
- SEND: t_sync=1, TxD = shreg[128]. The hold counter counts 0..BIT_CYCLES-1.
  - At wrap, shift left by 1 and increment bit_cntr.
  - When bit_cntr=128 and the hold counter wraps, go to FIN.
  - If r_acknowledge drops during SEND, pulse error, set t_sync=0 and TxD=0, and go to IDLE; the frame is discarded.
- FIN: a single cycle. t_sync=0, TxD=0, done=1, then go to IDLE.
- enable=0 in any state: hold the state, all counters, TxD and t_sync. No timeout accrues and done/error do not pulse.
- A reset in any cycle, including mid-frame, forces IDLE on the next edge; reset beats a simultaneous start.
- If r_acknowledge is already high when REQ is entered, the transition to SEND happens on the first REQ cycle.

## Timing
- Reset values: TxD=0, t_sync=0, busy=0, done=0, error=0, state=IDLE, shift register=0, all counters=0.
- start sampled at edge 0 → t_sync=1 and busy=1 from cycle 1.
- r_acknowledge sampled high at edge k in REQ → frame bit 0 (mode) is on TxD from cycle k+1.
- Bit i (0..128) occupies cycles k+1+i·BIT_CYCLES .. k+(i+1)·BIT_CYCLES.
- done is high in cycle k+1+129·BIT_CYCLES; t_sync falls in that same cycle; busy falls one cycle later.
- With BIT_CYCLES=1, the remote receiver's counter sees mode at count 0, result[127] at 1, …, result[0] at 128.
- Timeout: with no ack, error pulses in cycle 1+ACK_TIMEOUT (with enable held high) and t_sync is low in the following cycle.
- All outputs are registered; no combinational path exists from input to output.

## Test plan
- Basic, BIT_CYCLES=1: mode=1, result=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, start, ack held high 2 cycles after t_sync → TxD carries 1 followed by the result MSB-first over 129 consecutive cycles; done pulses once; t_sync falls with done.
- BIT_CYCLES=4, mode=0, result=128'h8000…0001 → each bit is held exactly 4 cycles; high only in the bit-1 and bit-128 windows; done at k+1+516.
- Timeout, ACK_TIMEOUT=16, ack never raised → error pulses at cycle 17; t_sync, busy and TxD are 0 afterwards; done never pulses.
- Ack dropped after bit 40 → error pulse and TxD=0/t_sync=0 next cycle; a new start then sends a full correct frame.
- A start pulse during SEND, and enable low for 10 cycles mid-frame → the second start is ignored; TxD and the counters freeze during enable low and the frame resumes intact.
- reset_b asserted at bit 60, and reset coincident with start → all outputs return to reset values on the next edge; no frame starts.
